// File: rtl/iomem_cmd_pkg.sv
// Shared opcodes, status bytes, FSM states and opcode decode helpers for the iomem command initiator.
// Pure definitions: no latency, no backpressure.
package iomem_cmd_pkg;

    localparam logic [7:0] OP_READ       = 8'h52;
    localparam logic [7:0] OP_WRITE      = 8'h57;
    localparam logic [7:0] OP_WSTRB_BASE = 8'h60;

    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_TIMEOUT    = 8'hEE;
    localparam logic [7:0] ST_BADOP      = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RSP
    } state_t;

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE) || (op[7:4] == OP_WSTRB_BASE[7:4]);
    endfunction

    // 0x60 decodes to a zero strobe, which is still a legal bus write.
    function automatic logic [3:0] op_wstrb(input logic [7:0] op);
        if (op == OP_WRITE)
            return 4'hF;
        else if (op[7:4] == OP_WSTRB_BASE[7:4])
            return op[3:0];
        else
            return 4'h0;
    endfunction

endpackage

// File: rtl/iomem_cmd_initiator_if.sv
// Command byte stream, response byte stream and iomem initiator signals in one bundle.
// master = the initiator; slave = the command source, response sink and iomem responder.
interface iomem_cmd_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_data, rsp_ready, iomem_ready, iomem_rdata,
        output cmd_ready, rsp_valid, rsp_data, iomem_valid, iomem_wstrb,
               iomem_addr, iomem_wdata, busy
    );

    modport slave (
        output cmd_valid, cmd_data, rsp_ready, iomem_ready, iomem_rdata,
        input  cmd_ready, rsp_valid, rsp_data, iomem_valid, iomem_wstrb,
               iomem_addr, iomem_wdata, busy
    );
endinterface

// File: rtl/iomem_cmd_rsp_ser.sv
// Response serializer: loads up to five bytes, emits them LSB first; first byte valid the cycle after load.
// Each byte is held stable while i_rsp_ready is low.
module iomem_cmd_rsp_ser (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [39:0] i_bytes,
    input  logic [2:0]  i_count,
    input  logic        i_rsp_ready,
    output logic        o_rsp_valid,
    output logic [7:0]  o_rsp_data,
    output logic        o_last
);
    logic [39:0] r_sh;
    logic [2:0]  r_cnt;
    logic        w_fire;

    assign o_rsp_valid = (r_cnt != 3'd0);
    assign o_rsp_data  = r_sh[7:0];
    assign w_fire      = o_rsp_valid & i_rsp_ready;
    assign o_last      = w_fire & (r_cnt == 3'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_bytes;
            r_cnt <= i_count;
        end else if (w_fire) begin
            r_sh  <= {8'h00, r_sh[39:8]};
            r_cnt <= r_cnt - 3'd1;
        end
    end
endmodule

// File: rtl/iomem_cmd_initiator.sv
// Byte-stream to iomem bridge: opcode + LE addr (+ LE wdata) in, one bus access, status (+ LE rdata) out.
// iomem_valid rises the cycle after the last command byte; cmd_ready is low while the bus access or response is pending.
module iomem_cmd_initiator
    import iomem_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                   clk,
    input logic                   reset,
    iomem_cmd_initiator_if.master bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_bcnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic          r_is_write;
    logic [CW-1:0] r_tcnt;

    logic          w_cmd_ready;
    logic          w_cmd_fire;
    logic          w_tmo;
    logic          w_ser_load;
    logic [39:0]   w_ser_bytes;
    logic [2:0]    w_ser_cnt;
    logic          w_ser_last;

    assign w_cmd_ready = !reset && ((r_state == IDLE) || (r_state == ADDR) || (r_state == DATA));
    assign w_cmd_fire  = bus.cmd_valid & w_cmd_ready;
    // Expiry only when ready is absent, so a ready on the last allowed cycle still completes the access.
    assign w_tmo       = (TIMEOUT_CYCLES != 0) && (r_state == BUS) && !bus.iomem_ready
                         && (r_tcnt == CW'(TIMEOUT_CYCLES - 1));

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.iomem_valid = (r_state == BUS);
    assign bus.iomem_addr  = r_addr;
    assign bus.iomem_wdata = r_wdata;
    assign bus.iomem_wstrb = r_wstrb;
    assign bus.busy        = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_ser_load  = 1'b0;
        w_ser_bytes = '0;
        w_ser_cnt   = '0;
        case (r_state)
            IDLE: if (w_cmd_fire) begin
                if (op_known(bus.cmd_data)) begin
                    w_next = ADDR;
                end else begin
                    w_next      = RSP;
                    w_ser_load  = 1'b1;
                    w_ser_bytes = {32'h0, ST_BADOP};
                    w_ser_cnt   = 3'd1;
                end
            end
            ADDR: if (w_cmd_fire && (r_bcnt == 2'd3))
                w_next = r_is_write ? DATA : BUS;
            DATA: if (w_cmd_fire && (r_bcnt == 2'd3))
                w_next = BUS;
            BUS: if (bus.iomem_ready) begin
                w_next     = RSP;
                w_ser_load = 1'b1;
                if (r_is_write) begin
                    w_ser_bytes = {32'h0, ST_OK};
                    w_ser_cnt   = 3'd1;
                end else begin
                    w_ser_bytes = {bus.iomem_rdata, ST_OK};
                    w_ser_cnt   = 3'd5;
                end
            end else if (w_tmo) begin
                w_next      = RSP;
                w_ser_load  = 1'b1;
                w_ser_bytes = {32'h0, ST_TIMEOUT};
                w_ser_cnt   = 3'd1;
            end
            RSP: if (w_ser_last)
                w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcnt     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_is_write <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            if (w_cmd_fire) begin
                case (r_state)
                    IDLE: begin
                        r_wstrb    <= op_wstrb(bus.cmd_data);
                        r_is_write <= (bus.cmd_data != OP_READ);
                        r_bcnt     <= 2'd0;
                    end
                    ADDR: begin
                        r_addr <= {bus.cmd_data, r_addr[31:8]};
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                    DATA: begin
                        r_wdata <= {bus.cmd_data, r_wdata[31:8]};
                        r_bcnt  <= r_bcnt + 2'd1;
                    end
                    default: ;
                endcase
            end
            if ((r_state == BUS) && !bus.iomem_ready)
                r_tcnt <= r_tcnt + CW'(1);
            else
                r_tcnt <= '0;
        end
    end

    iomem_cmd_rsp_ser u_ser (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_ser_load),
        .i_bytes     (w_ser_bytes),
        .i_count     (w_ser_cnt),
        .i_rsp_ready (bus.rsp_ready),
        .o_rsp_valid (bus.rsp_valid),
        .o_rsp_data  (bus.rsp_data),
        .o_last      (w_ser_last)
    );
endmodule

// File: tb/tb_iomem_cmd_initiator.sv
// Bench for iomem_cmd_initiator: fixed command table, reset/stall sequences and randomized commands.
module tb_iomem_cmd_initiator;
    localparam int TMO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iomem_cmd_initiator_if bus();

    iomem_cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;       // responder ready delay in cycles, -1 = never
        int          exp_n;
        logic [39:0] exp_rsp;   // first response byte in bits [7:0]
        logic [3:0]  exp_wstrb;
        int          exp_vcyc;  // cycles iomem_valid is high
        bit          exp_tx;    // a completed bus access is expected
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } tx_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          lat    = 0;
    logic [31:0] rd_val = '0;
    int          vcnt   = 0;
    int          vcyc   = 0;
    logic [7:0]  rsp_q[$];
    tx_t         tx_q[$];

    logic        pv_valid = 1'b0, pv_ready = 1'b0, pr_valid = 1'b0, pr_ready = 1'b0;
    logic [31:0] pv_addr = '0, pv_wdata = '0;
    logic [3:0]  pv_wstrb = '0;
    logic [7:0]  pr_data = '0;

    // Responder: ready once valid has been waiting lat cycles (lat 0 = same cycle as valid).
    assign bus.iomem_ready = bus.iomem_valid && (lat >= 0) && (vcnt >= lat);
    assign bus.iomem_rdata = rd_val;

    always @(posedge clk)
        vcnt <= (bus.iomem_valid && !bus.iomem_ready) ? vcnt + 1 : 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            pv_valid = 1'b0;
            pr_valid = 1'b0;
        end else begin
            if (bus.iomem_valid) begin
                vcyc++;
                if (pv_valid && !pv_ready) begin
                    chk("bus_hold_addr", bus.iomem_addr, pv_addr);
                    chk("bus_hold_wdata", bus.iomem_wdata, pv_wdata);
                    chk("bus_hold_wstrb", bus.iomem_wstrb, pv_wstrb);
                end
                if (bus.iomem_ready)
                    tx_q.push_back('{bus.iomem_addr, bus.iomem_wdata, bus.iomem_wstrb});
            end
            if (pr_valid && !pr_ready) begin
                chk("rsp_hold_valid", bus.rsp_valid, 1'b1);
                chk("rsp_hold_data", bus.rsp_data, pr_data);
            end
            if (bus.rsp_valid && bus.rsp_ready)
                rsp_q.push_back(bus.rsp_data);
            pv_valid = bus.iomem_valid;
            pv_ready = bus.iomem_ready;
            pv_addr  = bus.iomem_addr;
            pv_wdata = bus.iomem_wdata;
            pv_wstrb = bus.iomem_wstrb;
            pr_valid = bus.rsp_valid;
            pr_ready = bus.rsp_ready;
            pr_data  = bus.rsp_data;
        end
    end

    // Reference: outcome of one command from the opcode, responder delay and timeout rule.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   rd, wr, tmo;
        r   = v;
        rd  = (v.op == 8'h52);
        wr  = (v.op == 8'h57) || (v.op[7:4] == 4'h6);
        tmo = (v.lat < 0) || (v.lat >= TMO);
        r.exp_wstrb = (v.op == 8'h57) ? 4'hF : ((v.op[7:4] == 4'h6) ? v.op[3:0] : 4'h0);
        if (!rd && !wr) begin
            r.exp_n = 1; r.exp_rsp = 40'h3F; r.exp_vcyc = 0; r.exp_tx = 1'b0;
        end else if (tmo) begin
            r.exp_n = 1; r.exp_rsp = 40'hEE; r.exp_vcyc = TMO; r.exp_tx = 1'b0;
        end else begin
            r.exp_tx   = 1'b1;
            r.exp_vcyc = v.lat + 1;
            if (rd) begin
                r.exp_n = 5; r.exp_rsp = {v.rdata, 8'h00};
            end else begin
                r.exp_n = 1; r.exp_rsp = 40'h00;
            end
        end
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n  = 0;
        bit ok = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) cycle();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        while (!ok && n < 50) begin
            ok = bus.cmd_ready;
            cycle();
            n++;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'($urandom);
        chk("cmd_accept", ok, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input bit rnd);
        bit known, wr;
        int n = 0;
        known = (v.op == 8'h52) || (v.op == 8'h57) || (v.op[7:4] == 4'h6);
        wr    = known && (v.op != 8'h52);
        lat    = v.lat;
        rd_val = v.rdata;
        vcyc   = 0;
        rsp_q.delete();
        tx_q.delete();
        bus.rsp_ready = 1'b1;
        send_byte(v.op, rnd);
        if (known) for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8], rnd);
        if (wr)    for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8], rnd);
        while (rsp_q.size() < v.exp_n && n < 300) begin
            if (rnd) bus.rsp_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        chk("rsp_count", rsp_q.size(), v.exp_n);
        chk("cmd_ready_after_rsp", bus.cmd_ready, 1'b1);
        chk("busy_after_rsp", bus.busy, 1'b0);
        bus.rsp_ready = 1'b1;
        repeat (3) cycle();
        chk("no_extra_rsp", rsp_q.size(), v.exp_n);
        for (int i = 0; i < v.exp_n && i < rsp_q.size(); i++)
            chk("rsp_byte", rsp_q[i], v.exp_rsp[8*i +: 8]);
        chk("valid_cycles", vcyc, v.exp_vcyc);
        chk("bus_txn_count", tx_q.size(), v.exp_tx ? 1 : 0);
        if (v.exp_tx && tx_q.size() > 0) begin
            chk("bus_addr", tx_q[0].addr, v.addr);
            chk("bus_wstrb", tx_q[0].wstrb, v.exp_wstrb);
            if (wr) chk("bus_wdata", tx_q[0].wdata, v.wdata);
        end
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;

        //           op     addr          wdata         rdata         lat n  rsp             ws    vc tx
        tbl[0] = '{8'h52, 32'h03000000, 32'h0,        32'hA5A51234,  2, 5, 40'hA5A5123400, 4'h0, 3, 1'b1};
        tbl[1] = '{8'h57, 32'h03000000, 32'hDEADBEEF, 32'h0,         3, 1, 40'h00,         4'hF, 4, 1'b1};
        tbl[2] = '{8'h63, 32'h03000004, 32'h44332211, 32'h0,         0, 1, 40'h00,         4'h3, 1, 1'b1};
        tbl[3] = '{8'h52, 32'h03000008, 32'h0,        32'h0,        -1, 1, 40'hEE,         4'h0, 8, 1'b0};
        tbl[4] = '{8'h52, 32'h0300000C, 32'h0,        32'h01020304,  1, 5, 40'h0102030400, 4'h0, 2, 1'b1};
        tbl[5] = '{8'h00, 32'h0,        32'h0,        32'h0,         0, 1, 40'h3F,         4'h0, 0, 1'b0};
        tbl[6] = '{8'h60, 32'h12345678, 32'h0,        32'h0,         0, 1, 40'h00,         4'h0, 1, 1'b1};
        tbl[7] = '{8'h6F, 32'h03000010, 32'hCAFEF00D, 32'h0,         7, 1, 40'h00,         4'hF, 8, 1'b1};
        tbl[8] = '{8'h57, 32'h03000014, 32'h11111111, 32'h0,         8, 1, 40'hEE,         4'hF, 8, 1'b0};
        tbl[9] = '{8'hFF, 32'h0,        32'h0,        32'h0,         0, 1, 40'h3F,         4'h0, 0, 1'b0};

        repeat (3) cycle();
        chk("reset_iomem_valid", bus.iomem_valid, 1'b0);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_cmd_ready", bus.cmd_ready, 1'b0);
        chk("reset_wstrb", bus.iomem_wstrb, 4'h0);
        chk("reset_addr", bus.iomem_addr, 32'h0);
        chk("reset_rsp_data", bus.rsp_data, 8'h00);
        reset = 1'b0;
        cycle();
        chk("post_reset_cmd_ready", bus.cmd_ready, 1'b1);

        foreach (tbl[i]) run_vec(tbl[i], 1'b0);

        // Unknown opcode with the response held off for 5 cycles.
        rsp_q.delete();
        vcyc = 0;
        bus.rsp_ready = 1'b0;
        send_byte(8'h00, 1'b0);
        chk("badop_rsp_latency", bus.rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", bus.rsp_valid, 1'b1);
            chk("stall_rsp_data", bus.rsp_data, 8'h3F);
            chk("stall_cmd_ready", bus.cmd_ready, 1'b0);
            cycle();
        end
        bus.rsp_ready = 1'b1;
        cycle();
        chk("stall_rsp_count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) chk("stall_rsp_byte", rsp_q[0], 8'h3F);
        chk("stall_no_bus", vcyc, 0);
        chk("stall_cmd_ready_after", bus.cmd_ready, 1'b1);

        // Reset while the bus access is outstanding.
        lat = -1;
        send_byte(8'h52, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
        chk("bus_valid_rise", bus.iomem_valid, 1'b1);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        chk("rst_bus_iomem_valid", bus.iomem_valid, 1'b0);
        chk("rst_bus_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_bus_busy", bus.busy, 1'b0);
        reset = 1'b0;
        cycle();
        chk("rst_bus_cmd_ready", bus.cmd_ready, 1'b1);

        // Reset while a read response is waiting to be consumed.
        lat = 0;
        rd_val = 32'h5555AAAA;
        bus.rsp_ready = 1'b0;
        send_byte(8'h52, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1'b0);
        cycle();
        chk("rst_rsp_pending", bus.rsp_valid, 1'b1);
        reset = 1'b1;
        cycle();
        chk("rst_rsp_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_iomem_valid", bus.iomem_valid, 1'b0);
        chk("rst_rsp_busy", bus.busy, 1'b0);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        rsp_q.delete();
        repeat (10) cycle();
        chk("rst_rsp_no_stale", rsp_q.size(), 0);
        chk("rst_rsp_cmd_ready", bus.cmd_ready, 1'b1);

        for (int k = 0; k < 40; k++) begin
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            case ($urandom_range(0, 3))
                0:       v.op = 8'h52;
                1:       v.op = 8'h57;
                2:       v.op = {4'h6, 4'($urandom)};
                default: v.op = 8'($urandom);
            endcase
            v.lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 10));
            v = model(v);
            run_vec(v, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
